// File: rtl/mem_wait_responder_pkg.sv
// rtl/mem_wait_responder_pkg.sv - shared state encoding and control-word field indices
package mem_wait_responder_pkg;

    localparam int CTRL_W    = 22;
    localparam int CW_RD_BIT = 0;
    localparam int CW_WR_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } resp_state_e;

endpackage

// File: rtl/mem_wait_responder_mem_array.sv
// rtl/mem_wait_responder_mem_array.sv - single-port synchronous word RAM
module mem_array #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; rdata is a registered read of addr.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_wait_responder.sv
// rtl/mem_wait_responder.sv - wait-state memory responder for the microprogrammed controller
module mem_wait_responder
    import mem_wait_responder_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 3,
    parameter int RD_BIT  = CW_RD_BIT,
    parameter int WR_BIT  = CW_WR_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] bus_controller,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              wait_,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              err
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    resp_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              op_wr_q, op_wr_d;
    logic              wait_q, wait_d;
    logic              dv_q, dv_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic              rd, wr, req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              ctrl_unused;

    assign rd          = bus_controller[RD_BIT];
    assign wr          = bus_controller[WR_BIT];
    assign req         = rd | wr;
    assign ctrl_unused = ^bus_controller;

    // In IDLE the RAM looks at the live address so a read is already primed
    // when a single-cycle latency reaches its completion edge.
    assign mem_addr = (state_q == ST_IDLE) ? addr_in : addr_q;

    mem_array #(
        .DEPTH  (2 ** ADDR_W),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        wait_d  = wait_q;
        dv_d    = dv_q;
        err_d   = err_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                dv_d = 1'b0;
                if (req) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                    addr_d  = addr_in;
                    wdata_d = data_in;
                    op_wr_d = wr;
                    wait_d  = 1'b1;
                    if (rd && wr) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    wait_d  = 1'b0;
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        dout_d = mem_rdata;
                        dv_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                // Hold here until the controller releases the strobes.
                if (!req) begin
                    state_d = ST_IDLE;
                    dv_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = 1'b0;
                dv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            wait_q  <= 1'b0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            wait_q  <= wait_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign wait_      = wait_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// tb/tb_mem_wait_responder.sv - randomized self-checking bench for mem_wait_responder
module tb_mem_wait_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] bus_controller = '0;
    logic [11:0] addr_in = '0;
    logic [15:0] data_in = '0;
    logic        wait_;
    logic [15:0] data_out;
    logic        data_valid;
    logic        err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] model_mem [int];
    logic [15:0] model_last_read = '0;
    logic        model_err = 1'b0;

    always #5 clk = ~clk;

    mem_wait_responder #(
        .DATA_W (16),
        .ADDR_W (12),
        .LATENCY(LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus_controller (bus_controller),
        .addr_in        (addr_in),
        .data_in        (data_in),
        .wait_          (wait_),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .err            (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        addr_in = 12'($urandom);
        data_in = 16'($urandom);
    endtask

    // One complete four-phase access; the model decides what each phase should show.
    task automatic access(input bit rd, input bit wr, input logic [11:0] a,
                          input logic [15:0] d, input int hold, input bit drop_mid);
        int  n;
        bit  exp_dv;
        bus_controller      = '0;
        bus_controller[0]   = rd;
        bus_controller[1]   = wr;
        addr_in             = a;
        data_in             = d;
        if (wr) model_mem[int'(a)] = d;
        if (rd && wr) model_err = 1'b1;
        if (rd && !wr) model_last_read = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'hxxxx;
        exp_dv = rd && !wr;

        tick();
        check_eq("wait_rise", 32'(wait_), 32'd1);
        n = 0;
        while (wait_ === 1'b1 && n < 20) begin
            tick();
            n++;
            if (drop_mid) bus_controller = '0;
            scramble_inputs();
        end
        check_eq("wait_cycles", n, LAT);
        check_eq("done_valid", 32'(data_valid), 32'(exp_dv));
        check_eq("done_data", 32'(data_out), 32'(model_last_read));
        check_eq("done_err", 32'(err), 32'(model_err));
        if (!drop_mid) begin
            for (int i = 0; i < hold; i++) begin
                tick();
                check_eq("hold_wait", 32'(wait_), 32'd0);
                check_eq("hold_valid", 32'(data_valid), 32'(exp_dv));
            end
            bus_controller = '0;
        end
        tick();
        check_eq("idle_valid", 32'(data_valid), 32'd0);
        check_eq("idle_wait", 32'(wait_), 32'd0);
        check_eq("idle_data", 32'(data_out), 32'(model_last_read));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] pool [16];
        int          k;
        bit          r, w;

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("rst_wait", 32'(wait_), 32'd0);
            check_eq("rst_valid", 32'(data_valid), 32'd0);
            check_eq("rst_err", 32'(err), 32'd0);
            check_eq("rst_data", 32'(data_out), 32'd0);
        end

        access(1'b0, 1'b1, 12'h005, 16'hBEEF, 0, 1'b0);
        access(1'b1, 1'b0, 12'h005, 16'h0000, 0, 1'b0);
        access(1'b1, 1'b0, 12'h005, 16'h0000, 8, 1'b0);

        access(1'b1, 1'b1, 12'h010, 16'h1234, 1, 1'b0);
        access(1'b1, 1'b0, 12'h010, 16'h0000, 0, 1'b0);
        check_eq("err_sticky", 32'(err), 32'd1);

        // Abort a write in its second BUSY cycle; the old word must survive.
        access(1'b0, 1'b1, 12'h020, 16'h5555, 0, 1'b0);
        bus_controller = 22'b10;
        addr_in        = 12'h020;
        data_in        = 16'hAAAA;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("abort_wait", 32'(wait_), 32'd0);
        check_eq("abort_err", 32'(err), 32'd0);
        check_eq("abort_data", 32'(data_out), 32'd0);
        model_err       = 1'b0;
        model_last_read = '0;
        bus_controller  = '0;
        tick();
        rst = 1'b0;
        tick();
        access(1'b1, 1'b0, 12'h020, 16'h0000, 0, 1'b0);

        access(1'b0, 1'b1, 12'h000, 16'h7777, 0, 1'b0);
        access(1'b0, 1'b1, 12'hFFF, 16'h0F0F, 0, 1'b0);
        access(1'b1, 1'b0, 12'hFFF, 16'h0000, 0, 1'b0);
        access(1'b1, 1'b0, 12'h000, 16'h0000, 2, 1'b0);

        for (int i = 0; i < 16; i++) begin
            pool[i] = 12'($urandom);
            access(1'b0, 1'b1, pool[i], 16'($urandom), 0, 1'b0);
        end
        for (int i = 0; i < 150; i++) begin
            k = int'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0, 1:    begin r = 1'b0; w = 1'b1; end
                5:       begin r = 1'b1; w = 1'b1; end
                default: begin r = 1'b1; w = 1'b0; end
            endcase
            access(r, w, pool[k], 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
